// File: rtl/shmemcpy.sv
// rtl/shmemcpy.sv - word copy engine driving one shared-memory arbiter port.
// Optional fill mode (pattern write, no reads) enabled by defining SHMEMCPY_FILL_EN.
module shmemcpy #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_src,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [ADDR_WIDTH:0]   cmd_len,
`ifdef SHMEMCPY_FILL_EN
  input  logic                  cmd_fill,
  input  logic [DATA_WIDTH-1:0] cmd_pattern,
`endif
  output logic                  busy,
  output logic                  cmd_done,
  output logic                  shmem_request,
  output logic                  shmem_wren,
  output logic [ADDR_WIDTH-1:0] shmem_addr,
  output logic [DATA_WIDTH-1:0] shmem_datain,
  input  logic [DATA_WIDTH-1:0] shmem_dataout,
  input  logic                  shmem_done
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  req_q, req_d;
  logic                  wren_q, wren_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  served;
`ifdef SHMEMCPY_FILL_EN
  logic                  fill_q, fill_d;
`endif

  // A done strobe only counts while a request is actually outstanding.
  assign served = req_q & shmem_done;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      req_q   <= 1'b0;
      wren_q  <= 1'b0;
      data_q  <= '0;
`ifdef SHMEMCPY_FILL_EN
      fill_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      req_q   <= req_d;
      wren_q  <= wren_d;
      data_q  <= data_d;
`ifdef SHMEMCPY_FILL_EN
      fill_q  <= fill_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    req_d   = req_q;
    wren_d  = wren_q;
    data_d  = data_q;
`ifdef SHMEMCPY_FILL_EN
    fill_d  = fill_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          src_d = cmd_src;
          dst_d = cmd_dst;
          rem_d = cmd_len;
          if (cmd_len == '0) begin
            state_d = FINISH;
          end else begin
            state_d = READ;
            req_d   = 1'b1;
            wren_d  = 1'b0;
            addr_d  = cmd_src;
`ifdef SHMEMCPY_FILL_EN
            fill_d  = cmd_fill;
            if (cmd_fill) begin
              state_d = WRITE;
              wren_d  = 1'b1;
              addr_d  = cmd_dst;
              data_d  = cmd_pattern;
            end
`endif
          end
        end
      end
      READ: begin
        if (served) begin
          data_d  = shmem_dataout;
          state_d = WRITE;
          wren_d  = 1'b1;
          addr_d  = dst_q;
        end
      end
      WRITE: begin
        if (served) begin
          src_d = src_q + 1'b1;
          dst_d = dst_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
            state_d = FINISH;
            req_d   = 1'b0;
            wren_d  = 1'b0;
          end else begin
            state_d = READ;
            wren_d  = 1'b0;
            addr_d  = src_q + 1'b1;
`ifdef SHMEMCPY_FILL_EN
            // Fill keeps writing the same pattern word to successive addresses.
            if (fill_q) begin
              state_d = WRITE;
              wren_d  = 1'b1;
              addr_d  = dst_q + 1'b1;
            end
`endif
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign cmd_done      = (state_q == FINISH);
  assign shmem_request = req_q;
  assign shmem_wren    = wren_q;
  assign shmem_addr    = addr_q;
  assign shmem_datain  = data_q;

endmodule

// File: tb/tb_shmemcpy.sv
// tb/tb_shmemcpy.sv - randomized scoreboard bench for shmemcpy against a word-array copy model.
// Fill-mode checks run when SHMEMCPY_FILL_EN is defined.
module tb_shmemcpy;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int N  = 4096;

  logic          clk = 1'b0;
  logic          srst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_src;
  logic [AW-1:0] cmd_dst;
  logic [AW:0]   cmd_len;
`ifdef SHMEMCPY_FILL_EN
  logic          cmd_fill;
  logic [DW-1:0] cmd_pattern;
`endif
  logic          busy;
  logic          cmd_done;
  logic          shmem_request;
  logic          shmem_wren;
  logic [AW-1:0] shmem_addr;
  logic [DW-1:0] shmem_datain;
  logic [DW-1:0] shmem_dataout;
  logic          shmem_done;

  shmemcpy #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .srst(srst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
`ifdef SHMEMCPY_FILL_EN
    .cmd_fill(cmd_fill), .cmd_pattern(cmd_pattern),
`endif
    .busy(busy), .cmd_done(cmd_done), .shmem_request(shmem_request),
    .shmem_wren(shmem_wren), .shmem_addr(shmem_addr), .shmem_datain(shmem_datain),
    .shmem_dataout(shmem_dataout), .shmem_done(shmem_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;

  logic [DW-1:0] ram   [N];
  logic [DW-1:0] model [N];
  acc_t          exp_q [$];

  int asserts = 0;
  int fails = 0;
  int done_count = 0;
  int acc_count = 0;
  int write_count = 0;
  int max_stall = 0;
  int stall_left = 0;
  int hold_after_writes = 32'h4000_0000;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Memory agent and monitor: serves requests with random stalls, scores each served access.
  initial begin : agent
    logic          p_done, p_req, p_wr;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;
    acc_t          e;
    p_done = 1'b0;
    p_req  = 1'b0;
    p_wr   = 1'b0;
    p_addr = '0;
    p_data = '0;
    shmem_done    = 1'b0;
    shmem_dataout = '0;
    forever begin
      @(negedge clk);
      if (cmd_done === 1'b1) done_count++;
      if (p_done) begin
        acc_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_access", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("acc_wren", {63'd0, p_wr}, {63'd0, e.wr});
          check("acc_addr", {52'd0, p_addr}, {52'd0, e.addr});
          if (e.wr) check("acc_data", {32'd0, p_data}, {32'd0, e.data});
        end
        if (p_wr) begin
          ram[p_addr] = p_data;
          write_count++;
        end
        stall_left = $urandom_range(max_stall, 0);
      end else if (p_req && shmem_request) begin
        check("stall_wren", {63'd0, shmem_wren}, {63'd0, p_wr});
        check("stall_addr", {52'd0, shmem_addr}, {52'd0, p_addr});
        check("stall_data", {32'd0, shmem_datain}, {32'd0, p_data});
      end
      p_req  = shmem_request;
      p_wr   = shmem_wren;
      p_addr = shmem_addr;
      p_data = shmem_datain;
      if (shmem_request === 1'b1 && !(shmem_wren && write_count >= hold_after_writes)
          && stall_left == 0) begin
        shmem_done    = 1'b1;
        shmem_dataout = ram[shmem_addr];
      end else begin
        shmem_done = 1'b0;
        if (shmem_request === 1'b1 && stall_left > 0) stall_left--;
        shmem_dataout = $urandom;
      end
      p_done = shmem_done;
    end
  end

  task automatic run_cmd(input int src, input int dst, input int len, input int fill,
                         input logic [DW-1:0] pattern, input int abort_writes);
    acc_t          e;
    logic [DW-1:0] d;
    int            base_done, base_acc, cyc;
    for (int i = 0; i < len; i++) begin
      if (fill != 0) begin
        d = pattern;
      end else begin
        d = model[(src + i) % N];
        e.wr = 1'b0; e.addr = AW'((src + i) % N); e.data = '0;
        exp_q.push_back(e);
      end
      e.wr = 1'b1; e.addr = AW'((dst + i) % N); e.data = d;
      exp_q.push_back(e);
      if (abort_writes < 0 || i < abort_writes) model[(dst + i) % N] = d;
    end
    base_done = done_count;
    base_acc  = acc_count;
    if (abort_writes >= 0) hold_after_writes = write_count + abort_writes;
    @(negedge clk); #1;
    check("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_src   = AW'(src);
    cmd_dst   = AW'(dst);
    cmd_len   = (AW + 1)'(len);
`ifdef SHMEMCPY_FILL_EN
    cmd_fill    = (fill != 0);
    cmd_pattern = pattern;
`endif
    @(negedge clk); #1;
    cmd_valid = 1'b0;
    if (len == 0) begin
      check("len0_done_pulse", {63'd0, cmd_done}, 64'd1);
      check("len0_no_request", {63'd0, shmem_request}, 64'd0);
    end
    if (abort_writes >= 0) begin
      cyc = 0;
      while (!(shmem_request && shmem_wren && write_count == hold_after_writes) && cyc < 2000) begin
        @(negedge clk); #1;
        cyc++;
      end
      check("abort_reach_write", {63'd0, (cyc < 2000)}, 64'd1);
      srst = 1'b1;
      @(negedge clk); #1;
      srst = 1'b0;
      check("abort_request_low", {63'd0, shmem_request}, 64'd0);
      check("abort_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      check("abort_no_done", {63'd0, cmd_done}, 64'd0);
      hold_after_writes = 32'h4000_0000;
      exp_q.delete();
      check("abort_done_count", 64'(done_count - base_done), 64'd0);
    end else begin
      cyc = 0;
      while (busy && cyc < 20000) begin
        @(negedge clk); #1;
        cyc++;
      end
      check("busy_timeout", {63'd0, busy}, 64'd0);
      check("done_pulses", 64'(done_count - base_done), 64'd1);
      check("access_count", 64'(acc_count - base_acc), 64'((fill != 0) ? len : 2 * len));
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    end
  endtask

  initial begin : stim
    int bad;
    for (int i = 0; i < N; i++) begin
      ram[i]   = $urandom;
      model[i] = ram[i];
    end
    srst      = 1'b1;
    cmd_valid = 1'b0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_len   = '0;
`ifdef SHMEMCPY_FILL_EN
    cmd_fill    = 1'b0;
    cmd_pattern = '0;
`endif
    repeat (3) @(negedge clk);
    #1;
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_cmd_done", {63'd0, cmd_done}, 64'd0);
    check("rst_request", {63'd0, shmem_request}, 64'd0);
    check("rst_wren", {63'd0, shmem_wren}, 64'd0);
    check("rst_addr", {52'd0, shmem_addr}, 64'd0);
    check("rst_datain", {32'd0, shmem_datain}, 64'd0);
    srst = 1'b0;

    max_stall = 0;
    run_cmd(0, 1024, 4, 0, '0, -1);
    run_cmd(77, 500, 0, 0, '0, -1);
    max_stall = 5;
    run_cmd(4094, 10, 4, 0, '0, -1);
    max_stall = 2;
    run_cmd(200, 300, 8, 0, '0, 2);
    run_cmd(500, 600, 5, 0, '0, -1);
    for (int k = 0; k < 8; k++) begin
      max_stall = $urandom_range(3, 0);
      run_cmd($urandom_range(N - 1, 0), $urandom_range(N - 1, 0), $urandom_range(24, 1), 0, '0, -1);
    end
    max_stall = 1;
    run_cmd(40, 42, 10, 0, '0, -1);
`ifdef SHMEMCPY_FILL_EN
    run_cmd(0, 100, 3, 1, 32'hDEADBEEF, -1);
    for (int i = 100; i < 103; i++) check("fill_word", {32'd0, ram[i]}, 64'hDEADBEEF);
`endif
    max_stall = 0;
    run_cmd(0, 100, N, 0, '0, -1);

    bad = 0;
    for (int i = 0; i < N; i++) if (ram[i] !== model[i]) bad++;
    check("ram_image", 64'(bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
